d2d_plane_tx_scheduler: RTL and testbench
=========================================

D2D_PLANE_TX_SCHEDULER -- requirements
Module: d2d_plane_tx_scheduler

Interface
REQ-001 Parameter PLANES, default 4, number of NoC planes sharing one die-to-die transmit link (2..8).
REQ-002 Parameter FLIT_W, default 64, flit payload width in bits.
REQ-003 Parameter CREDITS, default 8, receiver buffer depth per plane; credit counters are $clog2(CREDITS+1) bits wide.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  PLANES  per-plane flit valid.
REQ-007 in_head  input  PLANES  per-plane head-flit marker, qualified by in_valid.
REQ-008 in_tail  input  PLANES  per-plane tail-flit marker, qualified by in_valid; head and tail both set marks a single-flit packet.
REQ-009 in_data  input  PLANES*FLIT_W  per-plane flit payload.
REQ-010 in_ready  output  PLANES  per-plane accept; a flit transfers when in_valid[p] and in_ready[p] are both high.
REQ-011 out_valid  output  1  link flit valid (registered).
REQ-012 out_ready  input  1  link accept.
REQ-013 out_data  output  FLIT_W  link flit payload (registered).
REQ-014 out_plane  output  $clog2(PLANES)  plane index of out_data (registered).
REQ-015 out_tail  output  1  tail marker of out_data (registered).
REQ-016 credit_return  input  PLANES  one credit returned for plane p per cycle in which bit p is high.
REQ-017 credit_err  output  1  sticky flag; set by a credit return that would exceed CREDITS.

Function
REQ-018 Load condition: load = ~out_valid | out_ready; a new flit is accepted only when load is high.
REQ-019 A plane is eligible when in_valid[p] is high and credit[p] is nonzero; a credit_return arriving in the same cycle does not make a plane eligible.
REQ-020 Arbitration is round-robin and combinational: at most one in_ready bit is high, in_ready[p] = grant[p] & load, and there is no request-to-grant delay.
REQ-021 The round-robin pointer is updated only when an accepted flit has in_tail set; the new pointer gives highest priority to (granted plane + 1) mod PLANES.
REQ-022 Lock state machine, IDLE and LOCKED(p):
- IDLE -> LOCKED(p) when an accepted flit from plane p has head set and tail clear.
- LOCKED(p) -> IDLE when an accepted flit from plane p has tail set.
- In LOCKED(p) only plane p may be granted, even while plane p is ineligible; other planes stall.
REQ-023 In IDLE, a flit without head set is arbitrated normally. A single-flit packet leaves the state machine in IDLE and advances the pointer.
REQ-024 On acceptance, out_valid, out_data, out_plane and out_tail load on the next edge, giving one cycle of latency from input to output.
REQ-025 If load is high and nothing is granted, out_valid clears on the next edge. If out_valid is high and out_ready is low, all output registers hold unchanged.
REQ-026 Credit update per plane p, each cycle:
- Decrement by 1 when a flit from plane p is accepted.
- Increment by 1 when credit_return[p] is high.
- Both in the same cycle leaves the counter unchanged.
REQ-027 A credit_return to a counter already at CREDITS, with no same-cycle decrement, is ignored (the counter saturates) and sets credit_err; credit_err stays set until rst.
REQ-028 At most one flit is in flight per cycle, so sustained throughput is 1 flit per cycle with no bubbles while out_ready is high and credits are available.

Reset
REQ-029 While rst is high, and on the edge where it is sampled:
- out_valid=0, out_data=0, out_plane=0, out_tail=0.
- credit_err=0, every credit counter=CREDITS.
- Lock state=IDLE, pointer=plane 0 highest priority.
REQ-030 A reset asserted mid-packet discards the lock and any held output flit with no further handshake. in_ready stays 0 throughout the reset cycle.

Verification
REQ-031 Planes 0-3 each present continuous single-flit packets with out_ready=1 -> out_plane sequence 0,1,2,3,0,... with one flit per cycle; each counter reaches 0 after 8 flits and that plane's in_ready then stays low.
REQ-032 Plane 1 sends a 4-flit packet (H,B,B,T) while plane 0 requests continuously -> four consecutive plane-1 flits, then plane 2/3/0 per the pointer; plane 0 is never interleaved.
REQ-033 out_ready is held low for 3 cycles with out_valid=1 -> out_data/out_plane are stable and in_ready=0 for those cycles; the next flit follows the cycle after out_ready rises.
REQ-034 Plane 2 at credit 0 mid-packet, with plane 3 requesting -> no grant while LOCKED(2); credit_return[2] pulses once -> the plane-2 flit is accepted the following cycle.
REQ-035 credit_return[0]=1 with counter=8 and no send -> counter stays 8 and credit_err=1 from the next cycle until rst.
REQ-036 rst is asserted for 1 cycle while LOCKED(1) with out_valid=1 -> out_valid=0, all counters=8, and plane 0 is granted first afterwards.

Source files
------------

// File: rtl/d2d_plane_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// d2d_plane_tx_scheduler_if
// Bundles the per-plane flit inputs, the single die-to-die link output and
// the credit return path of the plane transmit scheduler.
//   in_valid/in_head/in_tail/in_data : per-plane flit source (PLANES lanes)
//   in_ready                         : per-plane accept (one-hot or zero)
//   out_valid/out_data/out_plane/out_tail, out_ready : link flit handshake
//   credit_return                    : one receiver credit per set bit
//   credit_err                       : sticky credit overflow flag
// Modports: slave = scheduler side, master = plane sources / link / receiver.
// PLANES and FLIT_W must match the parameters of the attached scheduler.
// ---------------------------------------------------------------------------
interface d2d_plane_tx_scheduler_if #(
   parameter int PLANES = 4,
   parameter int FLIT_W = 64
);
   localparam int PW = $clog2(PLANES);

   logic [PLANES-1:0]        in_valid;
   logic [PLANES-1:0]        in_head;
   logic [PLANES-1:0]        in_tail;
   logic [PLANES*FLIT_W-1:0] in_data;
   logic [PLANES-1:0]        in_ready;
   logic                     out_valid;
   logic                     out_ready;
   logic [FLIT_W-1:0]        out_data;
   logic [PW-1:0]            out_plane;
   logic                     out_tail;
   logic [PLANES-1:0]        credit_return;
   logic                     credit_err;

   modport slave (
      input  in_valid, in_head, in_tail, in_data, out_ready, credit_return,
      output in_ready, out_valid, out_data, out_plane, out_tail, credit_err
   );

   modport master (
      output in_valid, in_head, in_tail, in_data, out_ready, credit_return,
      input  in_ready, out_valid, out_data, out_plane, out_tail, credit_err
   );
endinterface

// File: rtl/d2d_plane_tx_scheduler.sv
// ---------------------------------------------------------------------------
// d2d_plane_tx_scheduler
// Merges PLANES NoC planes onto one die-to-die transmit link. A combinational
// round-robin arbiter picks one credited, valid plane per cycle; multi-flit
// packets lock the arbiter onto their plane until the tail is sent. The
// chosen flit is registered onto the link (one cycle latency, full rate).
// Per-plane credit counters track free receiver buffer slots.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   link : d2d_plane_tx_scheduler_if.slave (flit inputs, link output, credits)
// ---------------------------------------------------------------------------
module d2d_plane_tx_scheduler #(
   parameter int PLANES  = 4,
   parameter int FLIT_W  = 64,
   parameter int CREDITS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   d2d_plane_tx_scheduler_if.slave    link
);
   localparam int PW = $clog2(PLANES);
   localparam int CW = $clog2(CREDITS + 1);

   typedef enum logic {IDLE, LOCKED} lock_state_e;

   lock_state_e       state_q, state_d;
   logic [PW-1:0]     lock_plane_q, lock_plane_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     credit_q [PLANES];
   logic [CW-1:0]     credit_d [PLANES];
   logic              credit_err_q, credit_err_d;
   logic              out_valid_q, out_valid_d;
   logic [FLIT_W-1:0] out_data_q, out_data_d;
   logic [PW-1:0]     out_plane_q, out_plane_d;
   logic              out_tail_q, out_tail_d;

   logic              load;
   logic [PLANES-1:0] eligible;
   logic [PLANES-1:0] grant;
   logic [PLANES-1:0] in_ready;
   logic              accept;
   logic [PW-1:0]     gidx;
   logic [FLIT_W-1:0] sel_data;
   logic              sel_head, sel_tail;

   // Arbitration: a credit returned this cycle only counts from next cycle,
   // so eligibility looks at the registered counter alone.
   always_comb begin : arbiter
      int  idx;
      logic found;
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      idx   = 0;
      found = 1'b0;
      grant = '0;
      gidx  = '0;
      load  = ~out_valid_q | link.out_ready;
      for (int p = 0; p < PLANES; p++) begin
         eligible[p] = link.in_valid[p] & (credit_q[p] != '0);
      end
      if (state_q == LOCKED) begin
         // Only the locked plane may go, even while it has no credit.
         grant[lock_plane_q] = eligible[lock_plane_q];
         gidx                = lock_plane_q;
      end else begin
         for (int i = 0; i < PLANES; i++) begin
            idx = (int'(ptr_q) + i) % PLANES;
            if (!found && eligible[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               gidx       = PW'(idx);
            end
         end
      end
      in_ready = grant & {PLANES{load & ~rst}};
      accept   = |in_ready;
   end

   // One-hot grant selects the accepted flit's payload and markers.
   always_comb begin : flit_mux
      sel_data = '0;
      sel_head = 1'b0;
      sel_tail = 1'b0;
      for (int p = 0; p < PLANES; p++) begin
         if (grant[p]) begin
            sel_data = link.in_data[p*FLIT_W +: FLIT_W];
            sel_head = link.in_head[p];
            sel_tail = link.in_tail[p];
         end
      end
   end

   // Next state: lock FSM, pointer, output register, credit counters.
   always_comb begin : next_state
      state_d      = state_q;
      lock_plane_d = lock_plane_q;
      ptr_d        = ptr_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_plane_d  = out_plane_q;
      out_tail_d   = out_tail_q;
      credit_err_d = credit_err_q;

      case (state_q)
         IDLE:   if (accept && sel_head && !sel_tail) begin
                    state_d      = LOCKED;
                    lock_plane_d = gidx;
                 end
         LOCKED: if (accept && sel_tail) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Priority moves past the granted plane only at packet boundaries.
      if (accept && sel_tail) ptr_d = PW'((int'(gidx) + 1) % PLANES);

      if (load) begin
         out_valid_d = accept;
         if (accept) begin
            out_data_d  = sel_data;
            out_plane_d = gidx;
            out_tail_d  = sel_tail;
         end
      end

      for (int p = 0; p < PLANES; p++) begin
         credit_d[p] = credit_q[p];
         if (in_ready[p] && !link.credit_return[p]) begin
            credit_d[p] = credit_q[p] - CW'(1);
         end else if (link.credit_return[p] && !in_ready[p]) begin
            if (credit_q[p] == CW'(CREDITS)) credit_err_d = 1'b1;
            else                             credit_d[p]  = credit_q[p] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q      <= IDLE;
         lock_plane_q <= '0;
         ptr_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_plane_q  <= '0;
         out_tail_q   <= 1'b0;
         credit_err_q <= 1'b0;
         // NOTE: the credit array is a handful of flops, not a RAM, so every
         // entry is reset to a full buffer.
         for (int p = 0; p < PLANES; p++) credit_q[p] <= CW'(CREDITS);
      end else begin
         state_q      <= state_d;
         lock_plane_q <= lock_plane_d;
         ptr_q        <= ptr_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_plane_q  <= out_plane_d;
         out_tail_q   <= out_tail_d;
         credit_err_q <= credit_err_d;
         for (int p = 0; p < PLANES; p++) credit_q[p] <= credit_d[p];
      end
   end

   assign link.in_ready   = in_ready;
   assign link.out_valid  = out_valid_q;
   assign link.out_data   = out_data_q;
   assign link.out_plane  = out_plane_q;
   assign link.out_tail   = out_tail_q;
   assign link.credit_err = credit_err_q;
endmodule

// File: tb/tb_d2d_plane_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_d2d_plane_tx_scheduler
// Directed scenarios followed by a randomized phase. A behavioural model
// (integer credits, lock plane number, priority plane number) predicts
// in_ready each cycle and the link output after each edge.
// ---------------------------------------------------------------------------
module tb_d2d_plane_tx_scheduler;
   localparam int PLANES  = 4;
   localparam int FLIT_W  = 64;
   localparam int CREDITS = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   d2d_plane_tx_scheduler_if #(.PLANES(PLANES), .FLIT_W(FLIT_W)) bus ();

   d2d_plane_tx_scheduler #(.PLANES(PLANES), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int          m_cred [PLANES];
   int          m_lock;            // -1 = no packet in progress
   int          m_ptr;             // plane with highest priority
   bit          m_err;
   bit          e_valid;
   logic [63:0] e_data;
   int          e_plane;
   bit          e_tail;
   bit          e_was_rst;
   int          last_g;

   // Sources: 0 off, 1 endless single-flit packets, 2 one packet of rem
   // flits, 3 random packets. A presented flit is held until accepted.
   int mode [PLANES];
   int rem  [PLANES];
   bit first[PLANES];
   bit pending[PLANES];
   int seq = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < PLANES; p++) m_cred[p] = CREDITS;
      m_lock = -1; m_ptr = 0; m_err = 0;
      e_valid = 0; e_data = '0; e_plane = 0; e_tail = 0;
   endtask

   function automatic int m_grant();
      if (rst || !(!e_valid || bus.out_ready)) return -1;
      if (m_lock >= 0) return (bus.in_valid[m_lock] && m_cred[m_lock] > 0) ? m_lock : -1;
      for (int i = 0; i < PLANES; i++) begin
         int p;
         p = (m_ptr + i) % PLANES;
         if (bus.in_valid[p] && m_cred[p] > 0) return p;
      end
      return -1;
   endfunction

   task automatic set_src(input int p, input int m, input int r);
      mode[p] = m; rem[p] = r; first[p] = 1; pending[p] = 0;
      bus.in_valid[p] = 1'b0;
   endtask

   task automatic present(input int p, input bit h, input bit t);
      bus.in_valid[p] = 1'b1;
      bus.in_head[p]  = h;
      bus.in_tail[p]  = t;
      bus.in_data[p*FLIT_W +: FLIT_W] = {8'(p), 24'(seq), 32'($urandom)};
      seq++;
      pending[p] = 1;
   endtask

   task automatic drive();
      for (int p = 0; p < PLANES; p++) begin
         if (!pending[p]) begin
            bus.in_valid[p] = 1'b0;
            case (mode[p])
               1: present(p, 1'b1, 1'b1);
               2: if (rem[p] > 0) present(p, first[p], rem[p] == 1);
               3: begin
                  if (rem[p] == 0 && $urandom_range(0, 1) == 1) begin
                     rem[p] = int'($urandom_range(1, 4)); first[p] = 1;
                  end
                  if (rem[p] > 0 && $urandom_range(0, 2) != 0) present(p, first[p], rem[p] == 1);
               end
               default: ;
            endcase
         end
      end
   endtask

   // One clock: predict and check in_ready mid-cycle, advance the model,
   // then check the registered outputs just after the edge.
   task automatic cycle();
      logic [PLANES-1:0] exp_rdy;
      bit ld;
      @(negedge clk);
      last_g  = m_grant();
      exp_rdy = (last_g >= 0) ? PLANES'(1 << last_g) : '0;
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      ld = !e_valid || bus.out_ready;
      e_was_rst = rst;
      if (rst) begin
         model_reset();
      end else begin
         if (last_g >= 0) begin
            e_valid = 1;
            e_data  = bus.in_data[last_g*FLIT_W +: FLIT_W];
            e_plane = last_g;
            e_tail  = bus.in_tail[last_g];
            if (m_lock < 0 && bus.in_head[last_g] && !bus.in_tail[last_g]) m_lock = last_g;
            else if (m_lock == last_g && bus.in_tail[last_g]) m_lock = -1;
            if (bus.in_tail[last_g]) m_ptr = (last_g + 1) % PLANES;
            pending[last_g] = 0;
            if (mode[last_g] >= 2) begin rem[last_g]--; first[last_g] = 0; end
         end else if (ld) begin
            e_valid = 0;
         end
         for (int p = 0; p < PLANES; p++) begin
            bit dec, inc;
            dec = (last_g == p);
            inc = bus.credit_return[p];
            if (dec && !inc) m_cred[p]--;
            else if (inc && !dec) begin
               if (m_cred[p] == CREDITS) m_err = 1;
               else m_cred[p]++;
            end
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", 64'(bus.out_valid), 64'(e_valid));
      check("credit_err", 64'(bus.credit_err), 64'(m_err));
      if (e_valid || e_was_rst) begin
         check("out_data", bus.out_data, e_data);
         check("out_plane", 64'(bus.out_plane), 64'(e_plane));
         check("out_tail", 64'(bus.out_tail), 64'(e_tail));
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1; drive(); cycle(); rst = 1'b0;
   endtask

   task automatic all_off();
      for (int p = 0; p < PLANES; p++) set_src(p, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_seq [7];
      logic [63:0] held_data;
      logic [1:0]  held_plane;

      rst = 1'b1;
      bus.in_valid = '0; bus.in_head = '0; bus.in_tail = '0; bus.in_data = '0;
      bus.out_ready = 1'b1; bus.credit_return = '0;
      model_reset();

      // Reset with all planes requesting: no accepts, cleared outputs.
      for (int p = 0; p < PLANES; p++) set_src(p, 1, 0);
      drive(); cycle(); cycle();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      rst = 1'b0;

      // Single-flit round robin until every plane runs out of credit.
      for (int k = 0; k < 36; k++) begin
         drive(); cycle();
         if (k < 32) check("rr_plane", 64'(bus.out_plane), 64'(k % PLANES));
         else        check("no_credit_ready", 64'(bus.in_ready), 64'd0);
      end

      // Four-flit packet on plane 1 is never interleaved.
      reset_dut();
      all_off(); set_src(0, 1, 0);
      drive(); cycle();
      check("setup_plane", 64'(bus.out_plane), 64'd0);
      set_src(1, 2, 4); set_src(2, 1, 0); set_src(3, 1, 0);
      exp_seq = '{1, 1, 1, 1, 2, 3, 0};
      for (int k = 0; k < 7; k++) begin
         drive(); cycle();
         check("pkt_plane", 64'(bus.out_plane), 64'(exp_seq[k]));
         check("pkt_tail", 64'(bus.out_tail), 64'(k >= 3));
      end

      // Link back-pressure: outputs hold, nothing accepted.
      drive(); cycle();
      check("pre_stall_plane", 64'(bus.out_plane), 64'd2);
      held_data = bus.out_data; held_plane = bus.out_plane;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(); cycle();
         check("stall_data", bus.out_data, held_data);
         check("stall_plane", 64'(bus.out_plane), 64'(held_plane));
         check("stall_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      drive(); cycle();
      check("post_stall_plane", 64'(bus.out_plane), 64'd3);

      // Locked plane 2 out of credit stalls plane 3 until a credit returns.
      reset_dut();
      all_off(); set_src(2, 2, 9); set_src(3, 1, 0);
      for (int k = 0; k < 8; k++) begin
         drive(); cycle();
         check("lock_plane", 64'(bus.out_plane), 64'd2);
      end
      for (int k = 0; k < 3; k++) begin
         drive(); cycle();
         check("lock_stall_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.credit_return = 4'b0100;
      drive(); cycle();
      bus.credit_return = '0;
      check("credit_back_ready", 64'(bus.in_ready), 64'b0100);
      drive(); cycle();
      check("lock_tail_plane", 64'(bus.out_plane), 64'd2);
      check("lock_tail_tail", 64'(bus.out_tail), 64'd1);
      drive(); cycle();
      check("after_lock_plane", 64'(bus.out_plane), 64'd3);

      // Credit overflow on a full counter is ignored and sticky.
      reset_dut();
      all_off();
      bus.credit_return = 4'b0001;
      drive(); cycle();
      bus.credit_return = '0;
      check("err_set", 64'(bus.credit_err), 64'd1);
      set_src(0, 1, 0);
      for (int k = 0; k < 10; k++) begin drive(); cycle(); end
      check("err_sticky", 64'(bus.credit_err), 64'd1);
      reset_dut();
      check("err_cleared", 64'(bus.credit_err), 64'd0);

      // Reset in the middle of a locked packet with a held output flit.
      all_off(); set_src(1, 2, 4);
      drive(); cycle();
      check("mid_pkt_valid", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b0;
      set_src(0, 1, 0);
      rst = 1'b1; drive(); cycle(); rst = 1'b0;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b1;
      set_src(1, 2, 1);
      drive(); cycle();
      check("post_rst_plane", 64'(bus.out_plane), 64'd0);

      // Randomized traffic, back-pressure, credit returns and resets.
      for (int p = 0; p < PLANES; p++) set_src(p, 3, 0);
      for (int k = 0; k < 3000; k++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         for (int p = 0; p < PLANES; p++) begin
            bus.credit_return[p] = (m_cred[p] < CREDITS && $urandom_range(0, 3) == 0) ||
                                   ($urandom_range(0, 499) == 0);
         end
         rst = ($urandom_range(0, 299) == 0);
         drive(); cycle();
      end
      rst = 1'b0;
      bus.credit_return = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
